// File: rtl/cla_restoring_divider_pkg.sv
// Shared encodings for the restoring divider and other adder consumers.
// Holds FSM state encoding and the adder add/subtract select values.
package cla_restoring_divider_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

endpackage

// File: rtl/cla_restoring_divider_cla.sv
// Block carry-lookahead adder/subtractor.
// Ports: a_i, b_i operands; add_sub_b_i 0=add 1=sub; sum_o, cout_o.
module carry_look_ahead_adder #(
    parameter int WIDTH       = 32,
    parameter int BLOCK_WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             add_sub_b_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    localparam int NBLK = WIDTH / BLOCK_WIDTH;

    always_comb begin
        logic [WIDTH-1:0] bx;
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] g;
        logic             c_blk;
        logic             c_bit;
        logic             term;
        logic             g_blk;
        logic             p_blk;
        // Subtract is a + ~b + 1: invert b and feed the select in as carry.
        bx    = b_i ^ {WIDTH{add_sub_b_i}};
        p     = a_i ^ bx;
        g     = a_i & bx;
        sum_o = '0;
        c_blk = add_sub_b_i;
        for (int k = 0; k < NBLK; k++) begin
            // In-block carries in flat sum-of-products form from block cin.
            for (int j = 0; j < BLOCK_WIDTH; j++) begin
                c_bit = c_blk;
                for (int m = 0; m < j; m++) begin
                    c_bit = c_bit & p[k*BLOCK_WIDTH+m];
                end
                for (int m = 0; m < j; m++) begin
                    term = g[k*BLOCK_WIDTH+m];
                    for (int n = m + 1; n < j; n++) begin
                        term = term & p[k*BLOCK_WIDTH+n];
                    end
                    c_bit = c_bit | term;
                end
                sum_o[k*BLOCK_WIDTH+j] = p[k*BLOCK_WIDTH+j] ^ c_bit;
            end
            g_blk = 1'b0;
            p_blk = 1'b1;
            for (int j = 0; j < BLOCK_WIDTH; j++) begin
                g_blk = g[k*BLOCK_WIDTH+j] | (p[k*BLOCK_WIDTH+j] & g_blk);
                p_blk = p_blk & p[k*BLOCK_WIDTH+j];
            end
            c_blk = g_blk | (p_blk & c_blk);
        end
        cout_o = c_blk;
    end

endmodule

// File: rtl/cla_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one CLA trial subtract per clock.
// Ports: clk, rst_n, start/dividend/divisor in; busy, done, quotient, remainder, div_by_zero out.
module cla_restoring_divider
    import cla_restoring_divider_pkg::*;
#(
    parameter int BUS_WIDTH       = 32,
    parameter int CLA_BLOCK_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [BUS_WIDTH-1:0] dividend,
    input  logic [BUS_WIDTH-1:0] divisor,
    output logic                 busy,
    output logic                 done,
    output logic [BUS_WIDTH-1:0] quotient,
    output logic [BUS_WIDTH-1:0] remainder,
    output logic                 div_by_zero
);

    localparam int AW = BUS_WIDTH + CLA_BLOCK_WIDTH;
    localparam int CW = $clog2(BUS_WIDTH);

    div_state_e           state_q, state_d;
    logic [BUS_WIDTH-1:0] q_work_q, q_work_d;
    logic [BUS_WIDTH-1:0] d_work_q, d_work_d;
    logic [AW-1:0]        r_work_q, r_work_d;
    logic [CW-1:0]        count_q, count_d;
    logic [BUS_WIDTH-1:0] quot_q, quot_d;
    logic [BUS_WIDTH-1:0] rem_q, rem_d;
    logic                 dbz_q, dbz_d;

    logic [AW-1:0]        shifted;
    logic [AW-1:0]        diff;
    logic                 sub_cout;
    logic                 qbit;
    logic [AW-1:0]        r_next;
    logic [BUS_WIDTH-1:0] q_next;
    logic                 unused_bits;

    assign shifted = AW'({r_work_q[BUS_WIDTH-1:0], q_work_q[BUS_WIDTH-1]});

    carry_look_ahead_adder #(
        .WIDTH       (AW),
        .BLOCK_WIDTH (CLA_BLOCK_WIDTH)
    ) u_trial_sub (
        .a_i         (shifted),
        .b_i         (AW'(d_work_q)),
        .add_sub_b_i (SUB),
        .sum_o       (diff),
        .cout_o      (sub_cout)
    );

    // A clear sign bit means the divisor fit: keep the difference.
    assign qbit   = ~diff[AW-1];
    assign r_next = qbit ? diff : shifted;
    assign q_next = {q_work_q[BUS_WIDTH-2:0], qbit};

    // Only the low half of the remainder is ever shifted back in.
    assign unused_bits = ^{r_work_q[AW-1:BUS_WIDTH], sub_cout};

    always_comb begin
        state_d  = state_q;
        q_work_d = q_work_q;
        d_work_d = d_work_q;
        r_work_d = r_work_q;
        count_d  = count_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        dbz_d    = dbz_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    q_work_d = dividend;
                    d_work_d = divisor;
                    r_work_d = '0;
                    count_d  = '0;
                    if (divisor == '0) begin
                        state_d = ST_DONE;
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                r_work_d = r_next;
                q_work_d = q_next;
                count_d  = count_q + CW'(1);
                if (count_q == CW'(BUS_WIDTH - 1)) begin
                    state_d = ST_DONE;
                    quot_d  = q_next;
                    rem_d   = r_next[BUS_WIDTH-1:0];
                    dbz_d   = 1'b0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            q_work_q <= '0;
            d_work_q <= '0;
            r_work_q <= '0;
            count_q  <= '0;
            quot_q   <= '0;
            rem_q    <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_work_q <= q_work_d;
            d_work_q <= d_work_d;
            r_work_q <= r_work_d;
            count_q  <= count_d;
            quot_q   <= quot_d;
            rem_q    <= rem_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule
